// File: rtl/serial_pkg.sv
// Shared definitions for the serial responder: UART FSM state encoding and line levels.
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_io_responder_if.sv
// Processor-side byte port between the memory stage (master) and the serial responder (slave).
interface serial_io_responder_if;

  logic       serial_wren_in;
  logic [7:0] serial_data_in;
  logic       serial_rden_in;
  logic [7:0] serial_data_out;
  logic       serial_valid_out;
  logic       serial_ready_out;

  modport master (
    output serial_wren_in, serial_data_in, serial_rden_in,
    input  serial_data_out, serial_valid_out, serial_ready_out
  );

  modport slave (
    input  serial_wren_in, serial_data_in, serial_rden_in,
    output serial_data_out, serial_valid_out, serial_ready_out
  );

endinterface

// File: rtl/serial_io_responder_byte_fifo.sv
// Show-ahead FIFO: head is valid combinationally, push/pop take effect on the next edge.
// Push while full and pop while empty are ignored; full/empty come from the registered count.
module byte_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_io_responder.sv
// Serial port peripheral: byte queues toward the memory stage, 8N1 UART transmitter/receiver on the line.
// TX line falls two edges after a push into an idle port; RX byte is visible the cycle after its stop sample.
module serial_io_responder
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_io_responder_if.slave  cpu,
  input  logic                  uart_rx_in,
  output logic                  uart_tx_out,
  output logic                  frame_err_out,
  output logic                  overrun_out
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  logic       tx_full, tx_empty, tx_pop;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty, rx_push;

  byte_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cpu.serial_wren_in),
    .push_data (cpu.serial_data_in),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  logic [7:0] rx_shreg;

  byte_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_shreg),
    .pop       (cpu.serial_rden_in),
    .head      (cpu.serial_data_out),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign cpu.serial_ready_out = !tx_full;
  assign cpu.serial_valid_out = !rx_empty;

  // ---------------- transmitter ----------------
  uart_state_t tx_state, tx_state_nxt;
  logic [TW-1:0] tx_timer, tx_timer_nxt;
  logic [2:0]    tx_idx, tx_idx_nxt;
  logic [7:0]    tx_shreg, tx_shreg_nxt;
  logic          tx_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state    <= S_IDLE;
      tx_timer    <= '0;
      tx_idx      <= '0;
      tx_shreg    <= '0;
      uart_tx_out <= UART_IDLE_LEVEL;
    end else begin
      tx_state    <= tx_state_nxt;
      tx_timer    <= tx_timer_nxt;
      tx_idx      <= tx_idx_nxt;
      tx_shreg    <= tx_shreg_nxt;
      uart_tx_out <= tx_bit;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_timer_nxt = tx_timer;
    tx_idx_nxt   = tx_idx;
    tx_shreg_nxt = tx_shreg;
    tx_pop       = 1'b0;
    tx_bit       = UART_IDLE_LEVEL;
    case (tx_state)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop       = 1'b1;
          tx_shreg_nxt = tx_head;
          tx_timer_nxt = '0;
          tx_idx_nxt   = '0;
          tx_state_nxt = S_START;
        end
      end
      S_START: begin
        tx_bit       = 1'b0;
        tx_timer_nxt = tx_timer + 1'b1;
        if (tx_timer == BIT_LAST) begin
          tx_timer_nxt = '0;
          tx_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        tx_bit       = tx_shreg[0];
        tx_timer_nxt = tx_timer + 1'b1;
        if (tx_timer == BIT_LAST) begin
          tx_timer_nxt = '0;
          tx_shreg_nxt = {1'b0, tx_shreg[7:1]};
          tx_idx_nxt   = tx_idx + 1'b1;
          if (tx_idx == 3'd7) tx_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        tx_timer_nxt = tx_timer + 1'b1;
        if (tx_timer == BIT_LAST) begin
          tx_timer_nxt = '0;
          tx_state_nxt = S_IDLE;
        end
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  logic [1:0] rx_sync;
  logic       rx_s, rx_prev;
  uart_state_t rx_state, rx_state_nxt;
  logic [TW-1:0] rx_timer, rx_timer_nxt;
  logic [2:0]    rx_idx, rx_idx_nxt;
  logic [7:0]    rx_shreg_nxt;
  logic          frame_err_nxt, overrun_nxt;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync       <= {2{UART_IDLE_LEVEL}};
      rx_prev       <= UART_IDLE_LEVEL;
      rx_state      <= S_IDLE;
      rx_timer      <= '0;
      rx_idx        <= '0;
      rx_shreg      <= '0;
      frame_err_out <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      rx_sync       <= {rx_sync[0], uart_rx_in};
      rx_prev       <= rx_s;
      rx_state      <= rx_state_nxt;
      rx_timer      <= rx_timer_nxt;
      rx_idx        <= rx_idx_nxt;
      rx_shreg      <= rx_shreg_nxt;
      frame_err_out <= frame_err_nxt;
      overrun_out   <= overrun_nxt;
    end
  end

  // START checks mid-bit; afterwards every sample lands a full bit later, i.e. mid-bit too.
  always_comb begin
    rx_state_nxt  = rx_state;
    rx_timer_nxt  = rx_timer;
    rx_idx_nxt    = rx_idx;
    rx_shreg_nxt  = rx_shreg;
    rx_push       = 1'b0;
    frame_err_nxt = 1'b0;
    overrun_nxt   = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_timer_nxt = '0;
          rx_state_nxt = S_START;
        end
      end
      S_START: begin
        rx_timer_nxt = rx_timer + 1'b1;
        if (rx_timer == HALF_LAST) begin
          rx_timer_nxt = '0;
          rx_idx_nxt   = '0;
          rx_state_nxt = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        rx_timer_nxt = rx_timer + 1'b1;
        if (rx_timer == BIT_LAST) begin
          rx_timer_nxt = '0;
          rx_shreg_nxt = {rx_s, rx_shreg[7:1]};
          rx_idx_nxt   = rx_idx + 1'b1;
          if (rx_idx == 3'd7) rx_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        rx_timer_nxt = rx_timer + 1'b1;
        if (rx_timer == BIT_LAST) begin
          rx_timer_nxt = '0;
          rx_state_nxt = S_IDLE;
          if (!rx_s)        frame_err_nxt = 1'b1;
          else if (rx_full) overrun_nxt   = 1'b1;
          else              rx_push       = 1'b1;
        end
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_io_responder.sv
// Directed-sequence bench with random payloads for serial_io_responder; queue-based reference model.
module tb_serial_io_responder;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  logic uart_rx, uart_tx, frame_err, overrun;
  logic rx_drv, loop_en;

  always #5 clk = ~clk;

  serial_io_responder_if cpu ();

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  serial_io_responder #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu           (cpu.slave),
    .uart_rx_in    (uart_rx),
    .uart_tx_out   (uart_tx),
    .frame_err_out (frame_err),
    .overrun_out   (overrun)
  );

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] tx_seen[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1)   ov_cnt <= ov_cnt + 1;
  end

  // Line-level decoder of whatever the transmitter emits, sampling mid-bit.
  initial begin : tx_decoder
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && reset === 1'b0) begin
        b = '0;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        tx_seen.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d);
    cpu.serial_wren_in = 1'b1;
    cpu.serial_data_in = d;
    @(negedge clk);
    cpu.serial_wren_in = 1'b0;
  endtask

  task automatic read_pulse();
    cpu.serial_rden_in = 1'b1;
    @(negedge clk);
    cpu.serial_rden_in = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  logic [7:0] d, lead;
  logic [7:0] exp_tx[$];
  logic [7:0] rx_exp[$];
  logic       exp_bit;
  int         fe0, ov0, exp_ov, model_cnt, waited;

  initial begin
    reset              = 1'b1;
    cpu.serial_wren_in = 1'b0;
    cpu.serial_data_in = '0;
    cpu.serial_rden_in = 1'b0;
    rx_drv             = 1'b1;
    loop_en            = 1'b0;
    #12;
    check("rst_tx", uart_tx, 1);
    check("rst_valid", cpu.serial_valid_out, 0);
    check("rst_ready", cpu.serial_ready_out, 1);
    check("rst_data", cpu.serial_data_out, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(3);

    // single byte: exact line waveform, bit by bit
    d = 8'h55;
    write_byte(d);
    check("tx_pre_start", uart_tx, 1);
    @(negedge clk);
    check("tx_k1_high", uart_tx, 1);
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i < CPB) exp_bit = 1'b0;
      else if (i >= 9 * CPB) exp_bit = 1'b1;
      else exp_bit = d[i / CPB - 1];
      check($sformatf("tx_wave_%0d", i), uart_tx, exp_bit);
    end
    @(negedge clk);
    check("tx_post_idle", uart_tx, 1);
    tick(4);
    check("tx_dec_cnt", tx_seen.size(), 1);
    if (tx_seen.size() > 0) check("tx_dec_byte", tx_seen[0], d);
    tx_seen.delete();

    // backpressure: line busy with a lead byte, then nine back-to-back writes
    lead = 8'($urandom);
    write_byte(lead);
    tick(5);
    model_cnt = 0;
    for (int n = 0; n < 9; n++) begin
      check($sformatf("bp_ready_%0d", n), cpu.serial_ready_out, (model_cnt < DEPTH) ? 1 : 0);
      d = 8'($urandom);
      cpu.serial_wren_in = 1'b1;
      cpu.serial_data_in = d;
      if (model_cnt < DEPTH) begin
        exp_tx.push_back(d);
        model_cnt++;
      end
      @(negedge clk);
    end
    cpu.serial_wren_in = 1'b0;
    waited = 0;
    while (tx_seen.size() < 9 && waited < 2200) begin
      @(negedge clk);
      waited++;
    end
    tick(300);
    check("bp_frames", tx_seen.size(), 9);
    if (tx_seen.size() > 0) check("bp_lead", tx_seen[0], lead);
    for (int i = 0; i < 8; i++)
      if (tx_seen.size() > i + 1) check($sformatf("bp_byte_%0d", i), tx_seen[i+1], exp_tx[i]);
    check("bp_ready_end", cpu.serial_ready_out, 1);
    tx_seen.delete();

    // RX single byte
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1);
    tick(4);
    check("rx_valid", cpu.serial_valid_out, 1);
    check("rx_data", cpu.serial_data_out, 8'hA5);
    read_pulse();
    check("rx_valid_after_rd", cpu.serial_valid_out, 0);

    // framing error
    d = 8'($urandom);
    send_frame(d, 1'b0);
    tick(CPB);
    check("ferr_pulses", fe_cnt - fe0, 1);
    check("ferr_valid", cpu.serial_valid_out, 0);
    check("ferr_no_ovr", ov_cnt - ov0, 0);

    // overrun: nine frames, no reads
    fe0 = fe_cnt;
    exp_ov = 0;
    for (int n = 0; n < 9; n++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1);
      if (rx_exp.size() < DEPTH) rx_exp.push_back(d);
      else exp_ov++;
    end
    tick(4);
    check("ovr_pulses", ov_cnt - ov0, exp_ov);
    check("ovr_no_ferr", fe_cnt - fe0, 0);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("ovr_valid_%0d", n), cpu.serial_valid_out, 1);
      check($sformatf("ovr_data_%0d", n), cpu.serial_data_out, rx_exp.pop_front());
      read_pulse();
    end
    check("ovr_drained", cpu.serial_valid_out, 0);

    // loopback
    loop_en = 1'b1;
    tick(2);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_exp.push_back(8'h00);
    rx_exp.push_back(8'hFF);
    rx_exp.push_back(8'h3C);
    cpu.serial_wren_in = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cpu.serial_data_in = rx_exp[n];
      @(negedge clk);
    end
    cpu.serial_wren_in = 1'b0;
    for (int n = 0; n < 3; n++) begin
      waited = 0;
      while (cpu.serial_valid_out !== 1'b1 && waited < 800) begin
        @(negedge clk);
        waited++;
      end
      check($sformatf("lb_valid_%0d", n), cpu.serial_valid_out, 1);
      check($sformatf("lb_data_%0d", n), cpu.serial_data_out, rx_exp[n]);
      read_pulse();
    end
    tick(20);
    check("lb_no_ferr", fe_cnt - fe0, 0);
    check("lb_no_ovr", ov_cnt - ov0, 0);
    check("lb_empty", cpu.serial_valid_out, 0);
    loop_en = 1'b0;
    tick(2);

    // asynchronous reset in the middle of a transmission
    send_frame(8'($urandom), 1'b1);
    tick(4);
    check("mid_valid_pre", cpu.serial_valid_out, 1);
    write_byte(8'h00);
    tick(40);
    check("mid_tx_low", uart_tx, 0);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_tx", uart_tx, 1);
    check("mid_rst_valid", cpu.serial_valid_out, 0);
    check("mid_rst_ready", cpu.serial_ready_out, 1);
    check("mid_rst_data", cpu.serial_data_out, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(CPB * 4);
    check("mid_post_tx", uart_tx, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
